ocx_tlx_rcv_cmd_queue: RTL
==========================

Name: ocx_tlx_rcv_cmd_queue

Overview:
- Receive-side command queue directly downstream of the TLX parse MAC.
- Captures parsed VC1 command info (fp_rcv_cmd_valid / fp_rcv_cmd_info) into a FIFO and presents it to the AFU over a valid/ready interface.
- Returns VC1 command credits to the transmit side as entries drain, including advertising the initial credit pool after reset.
- Sits between the parse MAC and the AFU command interface. It holds command info only; command data stays on the data-arb path.

Parameters:
- DEPTH, 16: number of command entries. Power of 2, from 4 to 64.
- INFO_W, 168: width of a command info entry. Matches the parser's fp_rcv_cmd_info.
- MAX_RET, 15: maximum credits returned in one pulse. Must be ≤ 2^CRED_W − 1.
- CRED_W, 4: width of the credit-return count field.

Ports:
- tlx_clk, in, 1: clock. All logic is on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- fp_rcv_cmd_valid, in, 1: parser command strobe. Single-cycle; cannot be backpressured.
- fp_rcv_cmd_info, in, INFO_W: parsed command info. Qualified by fp_rcv_cmd_valid.
- tlx_afu_cmd_valid, out, 1: head entry is valid.
- tlx_afu_cmd_info, out, INFO_W: head entry contents.
- afu_tlx_cmd_ready, in, 1: AFU accepts the head entry when this and tlx_afu_cmd_valid are both high.
- cmd_credit_return_v, out, 1: credit return pulse.
- cmd_credit_return_cnt, out, CRED_W: number of credits returned. Qualified by cmd_credit_return_v.
- cmd_queue_occupancy, out, clog2(DEPTH)+1: current number of entries held.
- cmd_queue_overflow, out, 1: sticky overflow error flag.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - read/write pointers and occupancy are 0.
  - tlx_afu_cmd_valid=0 and tlx_afu_cmd_info=0.
  - cmd_credit_return_v=0 and cmd_credit_return_cnt=0.
  - cmd_queue_overflow=0.
  - pending_credits=DEPTH (width clog2(DEPTH)+1).
  - Asserting reset mid-operation discards all entries and all unreturned credits; the initial advertisement then restarts.
- Storage:
  - Circular RAM of DEPTH×INFO_W.
  - Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
  - A separate occupancy counter distinguishes full from empty.
- Push:
  - push = fp_rcv_cmd_valid && (occupancy<DEPTH || pop).
  - On push, write at the write pointer and increment it.
- Pop:
  - pop = tlx_afu_cmd_valid && afu_tlx_cmd_ready.
  - On pop, increment the read pointer.
- Occupancy:
  - next = occupancy + push − pop.
  - A simultaneous push and pop leaves it unchanged, including when full and when holding 1 entry.
- Output timing (first-word fall-through):
  - tlx_afu_cmd_valid is combinational: occupancy≠0.
  - tlx_afu_cmd_info is the RAM entry at the read pointer.
  - An entry written in cycle N is visible in cycle N+1. There is no same-cycle bypass into an empty queue.
  - While tlx_afu_cmd_valid is high and afu_tlx_cmd_ready is low, tlx_afu_cmd_info holds stable.
- Overflow:
  - Condition: fp_rcv_cmd_valid with occupancy==DEPTH and no pop.
  - The entry is dropped; pointers and occupancy are unchanged.
  - cmd_queue_overflow sets and stays set until reset.
  - The dropped entry generates no credit.
- Credit return (registered, one pulse per cycle at most):
  - Each cycle: total = pending_credits + pop.
  - If total>0: next cycle cmd_credit_return_v=1, cmd_credit_return_cnt=min(total, MAX_RET), and pending_credits ← total − cnt.
  - Otherwise: cmd_credit_return_v=0, cmd_credit_return_cnt=0, and pending_credits holds.
  - A credit for a pop in cycle N is returned no earlier than cycle N+1.
  - With defaults, the first two cycles after reset release pulse cnt=15 then cnt=1.
  - Pops during the initial advertisement merge into pending_credits.
- Invariant, checked by assertion: occupancy + pending_credits + credits outstanding at the transmitter = DEPTH.
- Occupancy output is cmd_queue_occupancy = occupancy, taken directly from the register.

Test Plan:
- Release reset with no traffic → cmd_credit_return_v pulses at cycles 1 and 2 after release with cnt=15 then cnt=1, then stays 0. occupancy=0 and valid=0 throughout.
- Push 3 commands with info 0xA, 0xB, 0xC on consecutive cycles, ready=0 → occupancy reaches 3 and head=0xA. Raise ready for 3 cycles → info 0xA, 0xB, 0xC in order. Credit pulses of cnt=1 arrive each one cycle after its pop, and occupancy returns to 0.
- Fill to 16 with ready=0, then push a 17th (0xDEAD) → cmd_queue_overflow=1, occupancy=16, and 0xDEAD never appears at the output. Drain all 16 → exactly 16 credits returned, and overflow stays 1.
- Hold full with push and pop in the same cycle for 20 cycles → occupancy stays 16, overflow stays 0, output order is preserved across pointer wrap, and a cnt=1 credit pulse appears every cycle.
- Pop on the cycle immediately after reset release (entries preloaded are impossible, so instead pop in cycle 1 after a push at cycle 0) → that credit merges with the initial pool: total returned over the first cycles is 17, no single pulse exceeds 15, and there is never a gap cycle while pending_credits>0.
- Assert reset while occupancy=5 and pending_credits=3 → all outputs read 0 within the same cycle, and the post-release sequence matches the first scenario exactly.

Source files
------------

// File: rtl/ocx_tlx_rcv_cmd_queue.sv
// Receive-side VC1 command queue: buffers parsed command info from the parse MAC,
// presents it to the AFU first-word-fall-through, and returns VC1 command credits
// to the transmit side as entries drain (starting with the full pool after reset).
module ocx_tlx_rcv_cmd_queue #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned INFO_W  = 168,
  parameter int unsigned MAX_RET = 15,
  parameter int unsigned CRED_W  = 4
) (
  input  logic                     tlx_clk,
  input  logic                     reset,
  input  logic                     fp_rcv_cmd_valid,
  input  logic [INFO_W-1:0]        fp_rcv_cmd_info,
  output logic                     tlx_afu_cmd_valid,
  output logic [INFO_W-1:0]        tlx_afu_cmd_info,
  input  logic                     afu_tlx_cmd_ready,
  output logic                     cmd_credit_return_v,
  output logic [CRED_W-1:0]        cmd_credit_return_cnt,
  output logic [$clog2(DEPTH):0]   cmd_queue_occupancy,
  output logic                     cmd_queue_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned TOT_W = OCC_W + 1;

  logic [INFO_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [OCC_W-1:0]  pend_q, pend_d;
  logic              cr_v_q, cr_v_d;
  logic [CRED_W-1:0] cr_cnt_q, cr_cnt_d;
  logic              ovf_q, ovf_d;

  logic              full;
  logic              push;
  logic              pop;
  logic [TOT_W-1:0]  total;
  logic [TOT_W-1:0]  ret;

  // Handshake decode: a push into a full queue is only allowed when a pop frees the slot.
  always_comb begin
    full = (occ_q == OCC_W'(DEPTH));
    pop  = (occ_q != '0) && afu_tlx_cmd_ready;
    push = fp_rcv_cmd_valid && (!full || pop);
  end

  // Pointer, occupancy and sticky overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    ovf_d = ovf_q | (fp_rcv_cmd_valid && full && !pop);
  end

  // Credit return: fold this cycle's pop into the pending pool, emit up to MAX_RET.
  always_comb begin
    total    = TOT_W'(pend_q) + TOT_W'(pop);
    ret      = total;
    if (total > TOT_W'(MAX_RET)) begin
      ret = TOT_W'(MAX_RET);
    end
    cr_v_d   = (total != '0);
    cr_cnt_d = CRED_W'(ret);
    pend_d   = OCC_W'(total - ret);
  end

  // Control state; reset restores the full credit pool for re-advertisement.
  always_ff @(posedge tlx_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pend_q   <= OCC_W'(DEPTH);
      cr_v_q   <= 1'b0;
      cr_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pend_q   <= pend_d;
      cr_v_q   <= cr_v_d;
      cr_cnt_q <= cr_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; contents need no reset since the head is masked while empty.
  always_ff @(posedge tlx_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fp_rcv_cmd_info;
    end
  end

  // First-word-fall-through head; no bypass, so a write shows up the following cycle.
  always_comb begin
    tlx_afu_cmd_valid = (occ_q != '0);
    tlx_afu_cmd_info  = '0;
    if (tlx_afu_cmd_valid) begin
      tlx_afu_cmd_info = mem_q[rd_ptr_q];
    end
  end

  assign cmd_credit_return_v   = cr_v_q;
  assign cmd_credit_return_cnt = cr_cnt_q;
  assign cmd_queue_occupancy   = occ_q;
  assign cmd_queue_overflow    = ovf_q;

`ifndef SYNTHESIS
  // Shadow of credits held by the transmitter: gains each returned pulse, spends one per push.
  int tx_cred_q;
  always_ff @(posedge tlx_clk or posedge reset) begin
    if (reset) begin
      tx_cred_q <= 0;
    end else begin
      tx_cred_q <= tx_cred_q + (cr_v_d ? int'(cr_cnt_d) : 0) - int'(push);
    end
  end

  a_credit_conservation: assert property (@(posedge tlx_clk) disable iff (reset)
    (int'(occ_q) + int'(pend_q) + tx_cred_q) == int'(DEPTH));
`endif

endmodule
